// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serial memory stage: command field positions,
// length codes, FSM states and the byte-count helper.
package mem_pkg;

  localparam int MEM_E_EN     = 4;
  localparam int MEM_E_LEN_HI = 3;
  localparam int MEM_E_LEN_LO = 2;
  localparam int MEM_E_WR     = 1;
  localparam int MEM_E_UNS    = 0;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_RSVD = 2'd2;
  localparam logic [1:0] LEN_WORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TAIL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [2:0] byte_count(input logic [1:0] len);
    return {1'b0, len} + 3'd1;
  endfunction

endpackage

// File: rtl/mem_ext.sv
// Load extender: narrows the assembled little-endian load word to the access
// length and sign- or zero-extends it to 32 bits.
module mem_ext
  import mem_pkg::*;
(
  input  logic [31:0] i_ldata,
  input  logic [1:0]  i_len,
  input  logic        i_uns,
  output logic [31:0] o_wdata
);

  logic w_sign_b;
  logic w_sign_h;

  assign w_sign_b = ~i_uns & i_ldata[7];
  assign w_sign_h = ~i_uns & i_ldata[15];

  always_comb begin
    o_wdata = i_ldata;
    case (i_len)
      LEN_BYTE: o_wdata = {{24{w_sign_b}}, i_ldata[7:0]};
      LEN_HALF: o_wdata = {{16{w_sign_h}}, i_ldata[15:0]};
      default:  o_wdata = i_ldata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// EX->WB memory stage: byte-serial loads/stores over an 8-bit synchronous RAM port.
// Optional alignment trap enabled by defining MEM_ALIGN_CHK_EN.
module mem_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wa_i,
  input  logic        we_i,
  input  logic [31:0] res_i,
  input  logic [4:0]  mem_e_i,
  input  logic [31:0] mem_n_i,
  input  logic        bus_gnt_i,
  input  logic [7:0]  ram_din_i,
  output logic        stall_o,
  output logic [31:0] ram_a_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  output logic [4:0]  wa_o,
  output logic        we_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [31:0] r_ldata;
  logic [2:0]  r_cnt;
  logic [2:0]  r_n;
  logic [1:0]  r_len;
  logic        r_wr;
  logic        r_uns;
  logic        r_misal;
  logic [4:0]  r_wa;
  logic        r_we;
  logic        r_rd_pend;
  logic [1:0]  r_rd_idx;
  logic [4:0]  r_wb_wa;
  logic        r_wb_we;
  logic [31:0] r_wb_data;

  logic [1:0]  w_len;
  logic        w_req;
  logic        w_misal;
  logic        w_issue;
  logic        w_last;
  logic        w_stall;
  logic [31:0] w_ext;

  assign w_len   = mem_e_i[MEM_E_LEN_HI:MEM_E_LEN_LO];
  assign w_req   = mem_e_i[MEM_E_EN] && (w_len != LEN_RSVD);
  assign w_issue = (r_state == ST_BUSY) && bus_gnt_i;
  assign w_last  = (r_cnt == (r_n - 3'd1));

`ifdef MEM_ALIGN_CHK_EN
  logic r_misal_pulse;

  assign w_misal = ((w_len == LEN_HALF) && res_i[0]) ||
                   ((w_len == LEN_WORD) && (res_i[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misal_pulse <= 1'b0;
    else     r_misal_pulse <= (r_state == ST_DONE) && r_misal;
  end
  assign misalign_o = r_misal_pulse;
`else
  assign w_misal    = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_stall = 1'b1;
          w_next  = w_misal ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_stall = 1'b1;
        if (w_issue && w_last) w_next = r_wr ? ST_DONE : ST_TAIL;
      end
      ST_TAIL: begin
        w_stall = 1'b1;
        w_next  = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Reset must silence the pipeline hold even while EX still presents a request.
  assign stall_o    = w_stall & ~rst;
  assign ram_a_o    = w_issue ? (r_addr + {29'd0, r_cnt}) : 32'd0;
  assign ram_wr_o   = w_issue & r_wr;
  assign ram_dout_o = (w_issue && r_wr) ? r_sdata[{r_cnt[1:0], 3'b000} +: 8] : 8'd0;

  mem_ext u_ext (
    .i_ldata (r_ldata),
    .i_len   (r_len),
    .i_uns   (r_uns),
    .o_wdata (w_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= 32'd0;
      r_sdata   <= 32'd0;
      r_ldata   <= 32'd0;
      r_cnt     <= 3'd0;
      r_n       <= 3'd0;
      r_len     <= LEN_BYTE;
      r_wr      <= 1'b0;
      r_uns     <= 1'b0;
      r_misal   <= 1'b0;
      r_wa      <= 5'd0;
      r_we      <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_idx  <= 2'd0;
    end else begin
      r_state   <= w_next;
      r_rd_pend <= w_issue && !r_wr;
      r_rd_idx  <= r_cnt[1:0];
      // RAM data for an issued read arrives one cycle later, grant or not.
      if (r_rd_pend) r_ldata[{r_rd_idx, 3'b000} +: 8] <= ram_din_i;
      if ((r_state == ST_IDLE) && w_req) begin
        r_addr  <= res_i;
        r_sdata <= mem_n_i;
        r_ldata <= 32'd0;
        r_cnt   <= 3'd0;
        r_n     <= byte_count(w_len);
        r_len   <= w_len;
        r_wr    <= mem_e_i[MEM_E_WR];
        r_uns   <= mem_e_i[MEM_E_UNS];
        r_misal <= w_misal;
        r_wa    <= wa_i;
        r_we    <= we_i;
      end
      if (w_issue) r_cnt <= r_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_wa   <= 5'd0;
      r_wb_we   <= 1'b0;
      r_wb_data <= 32'd0;
    end else if (w_stall) begin
      r_wb_wa   <= 5'd0;
      r_wb_we   <= 1'b0;
      r_wb_data <= 32'd0;
    end else if (r_state == ST_DONE) begin
      r_wb_wa   <= r_wa;
      r_wb_we   <= r_we & ~r_wr & ~r_misal;
      r_wb_data <= r_misal ? 32'd0 : w_ext;
    end else begin
      r_wb_wa   <= wa_i;
      r_wb_we   <= we_i;
      r_wb_data <= res_i;
    end
  end

  assign wa_o    = r_wb_wa;
  assign we_o    = r_wb_we;
  assign wdata_o = r_wb_data;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a byte-wide synchronous RAM model.
// Alignment-trap expectations switch with MEM_ALIGN_CHK_EN.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wa_i;
  logic        we_i;
  logic [31:0] res_i;
  logic [4:0]  mem_e_i;
  logic [31:0] mem_n_i;
  logic        bus_gnt_i;
  logic [7:0]  ram_din_i;
  logic        stall_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [4:0]  wa_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic        misalign_o;

  logic [7:0]  ram [0:4095];
  logic        poke_en;
  logic [11:0] poke_a;
  logic [7:0]  poke_d;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] a_q [$];
  int          c_q [$];
  logic [7:0]  w_q [$];

  localparam logic [4:0] E_LB  = 5'b10000;
  localparam logic [4:0] E_LBU = 5'b10001;
  localparam logic [4:0] E_LH  = 5'b10100;
  localparam logic [4:0] E_LW  = 5'b11100;
  localparam logic [4:0] E_SH  = 5'b10110;
  localparam logic [4:0] E_SW  = 5'b11110;

  mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .wa_i       (wa_i),
    .we_i       (we_i),
    .res_i      (res_i),
    .mem_e_i    (mem_e_i),
    .mem_n_i    (mem_n_i),
    .bus_gnt_i  (bus_gnt_i),
    .ram_din_i  (ram_din_i),
    .stall_o    (stall_o),
    .ram_a_o    (ram_a_o),
    .ram_wr_o   (ram_wr_o),
    .ram_dout_o (ram_dout_o),
    .wa_o       (wa_o),
    .we_o       (we_o),
    .wdata_o    (wdata_o),
    .misalign_o (misalign_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_din_i <= ram[ram_a_o[11:0]];
    if (poke_en)       ram[poke_a] <= poke_d;
    else if (ram_wr_o) ram[ram_a_o[11:0]] <= ram_dout_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    poke_en = 1'b1;
    poke_a  = a;
    poke_d  = d;
    tick();
    poke_en = 1'b0;
  endtask

  // Emulates EX: holds the command while stall_o is high, logs bus activity per cycle.
  task automatic mem_op(input logic [4:0] e, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] wa, input logic we, input logic [15:0] gnt,
                        output int cycles, output int stalls);
    logic st;
    mem_e_i = e;
    res_i   = addr;
    mem_n_i = sd;
    wa_i    = wa;
    we_i    = we;
    a_q.delete();
    c_q.delete();
    w_q.delete();
    cycles = 0;
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      bus_gnt_i = (c < 16) ? gnt[c] : 1'b1;
      #4;
      if (ram_a_o != 32'd0 || ram_wr_o) begin
        a_q.push_back(ram_a_o);
        c_q.push_back(c);
      end
      if (ram_wr_o) w_q.push_back(ram_dout_o);
      st = stall_o;
      tick();
      cycles = c + 1;
      if (!st) break;
      stalls++;
    end
    mem_e_i   = 5'd0;
    res_i     = 32'd0;
    mem_n_i   = 32'd0;
    wa_i      = 5'd0;
    we_i      = 1'b0;
    bus_gnt_i = 1'b1;
  endtask

  int cyc;
  int stl;

  initial begin
    rst       = 1'b1;
    wa_i      = 5'd0;
    we_i      = 1'b0;
    res_i     = 32'd0;
    mem_e_i   = 5'd0;
    mem_n_i   = 32'd0;
    bus_gnt_i = 1'b1;
    poke_en   = 1'b0;
    poke_a    = 12'd0;
    poke_d    = 8'd0;

    #2;
    chk("rst_stall",   {31'd0, stall_o},    32'd0);
    chk("rst_ram_a",   ram_a_o,             32'd0);
    chk("rst_ram_wr",  {31'd0, ram_wr_o},   32'd0);
    chk("rst_ram_dout",{24'd0, ram_dout_o}, 32'd0);
    chk("rst_wa",      {27'd0, wa_o},       32'd0);
    chk("rst_we",      {31'd0, we_o},       32'd0);
    chk("rst_wdata",   wdata_o,             32'd0);
    chk("rst_misal",   {31'd0, misalign_o}, 32'd0);

    poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
    poke(12'h200, 8'h80);
    poke(12'h210, 8'h34); poke(12'h211, 8'h92);
    poke(12'h500, 8'h11); poke(12'h501, 8'h22); poke(12'h502, 8'h33); poke(12'h503, 8'h44);
    poke(12'h600, 8'h5A); poke(12'h601, 8'h5A); poke(12'h602, 8'h5A); poke(12'h603, 8'h5A);
    rst = 1'b0;
    tick();

    // ALU pass-through
    mem_op(5'd0, 32'h1234, 32'd0, 5'd5, 1'b1, 16'hFFFF, cyc, stl);
    $display("txn alu    : cycles=%0d stalls=%0d wdata=%08h we=%0d", cyc, stl, wdata_o, we_o);
    chk("alu_cycles", cyc, 1);
    chk("alu_stalls", stl, 0);
    chk("alu_wdata",  wdata_o, 32'h1234);
    chk("alu_we",     {31'd0, we_o}, 32'd1);
    chk("alu_wa",     {27'd0, wa_o}, 32'd5);

    // LW aligned
    mem_op(E_LW, 32'h100, 32'd0, 5'd7, 1'b1, 16'hFFFF, cyc, stl);
    $display("txn lw     : cycles=%0d stalls=%0d wdata=%08h", cyc, stl, wdata_o);
    chk("lw_cycles", cyc, 7);
    chk("lw_stalls", stl, 6);
    chk("lw_wdata",  wdata_o, 32'h12345678);
    chk("lw_we",     {31'd0, we_o}, 32'd1);
    chk("lw_wa",     {27'd0, wa_o}, 32'd7);
    chk("lw_naddr",  a_q.size(), 4);
    for (int i = 0; i < 4 && i < a_q.size(); i++) begin
      chk("lw_addr", a_q[i], 32'h100 + i);
      chk("lw_acyc", c_q[i], 1 + i);
    end

    // LB / LBU sign handling
    mem_op(E_LB, 32'h200, 32'd0, 5'd3, 1'b1, 16'hFFFF, cyc, stl);
    $display("txn lb     : cycles=%0d wdata=%08h", cyc, wdata_o);
    chk("lb_cycles", cyc, 4);
    chk("lb_wdata",  wdata_o, 32'hFFFFFF80);
    mem_op(E_LBU, 32'h200, 32'd0, 5'd3, 1'b1, 16'hFFFF, cyc, stl);
    $display("txn lbu    : cycles=%0d wdata=%08h", cyc, wdata_o);
    chk("lbu_cycles", cyc, 4);
    chk("lbu_wdata",  wdata_o, 32'h00000080);

    // LH signed
    mem_op(E_LH, 32'h210, 32'd0, 5'd4, 1'b1, 16'hFFFF, cyc, stl);
    $display("txn lh     : cycles=%0d wdata=%08h", cyc, wdata_o);
    chk("lh_cycles", cyc, 5);
    chk("lh_wdata",  wdata_o, 32'hFFFF9234);

    // SH to an odd address
    mem_op(E_SH, 32'h301, 32'hAABBCCDD, 5'd9, 1'b1, 16'hFFFF, cyc, stl);
    $display("txn sh     : cycles=%0d writes=%0d we=%0d misal=%0d", cyc, w_q.size(), we_o, misalign_o);
    chk("sh_we", {31'd0, we_o}, 32'd0);
`ifdef MEM_ALIGN_CHK_EN
    chk("sh_cycles", cyc, 2);
    chk("sh_nwr",    w_q.size(), 0);
    chk("sh_misal",  {31'd0, misalign_o}, 32'd1);
    tick();
    chk("sh_misal_end", {31'd0, misalign_o}, 32'd0);
`else
    chk("sh_cycles", cyc, 4);
    chk("sh_nwr",    w_q.size(), 2);
    chk("sh_misal",  {31'd0, misalign_o}, 32'd0);
    if (w_q.size() == 2) begin
      chk("sh_d0", {24'd0, w_q[0]}, 32'hDD);
      chk("sh_a0", a_q[0], 32'h301);
      chk("sh_d1", {24'd0, w_q[1]}, 32'hCC);
      chk("sh_a1", a_q[1], 32'h302);
    end
    tick();
    chk("sh_ram301", {24'd0, ram[12'h301]}, 32'hDD);
    chk("sh_ram302", {24'd0, ram[12'h302]}, 32'hCC);
`endif

    // LW with grant withdrawn for two cycles after byte 1
    mem_op(E_LW, 32'h500, 32'd0, 5'd11, 1'b1, 16'hFFE7, cyc, stl);
    $display("txn lw_gnt : cycles=%0d wdata=%08h", cyc, wdata_o);
    chk("lwg_cycles", cyc, 9);
    chk("lwg_wdata",  wdata_o, 32'h44332211);
    chk("lwg_naddr",  a_q.size(), 4);
    if (a_q.size() == 4) begin
      chk("lwg_acyc2", c_q[2], 5);
      chk("lwg_addr3", a_q[3], 32'h503);
    end

    // SW aborted by reset while byte 2 is on the bus
    mem_e_i   = E_SW;
    res_i     = 32'h600;
    mem_n_i   = 32'hCAFEBABE;
    wa_i      = 5'd2;
    we_i      = 1'b0;
    bus_gnt_i = 1'b1;
    #4;
    chk("swr_stall0", {31'd0, stall_o}, 32'd1);
    tick();
    tick();
    tick();
    chk("swr_b2_wr",   {31'd0, ram_wr_o},   32'd1);
    chk("swr_b2_a",    ram_a_o,             32'h602);
    chk("swr_b2_d",    {24'd0, ram_dout_o}, 32'hFE);
    rst = 1'b1;
    #1;
    chk("swr_wr",    {31'd0, ram_wr_o},   32'd0);
    chk("swr_ram_a", ram_a_o,             32'd0);
    chk("swr_dout",  {24'd0, ram_dout_o}, 32'd0);
    chk("swr_stall", {31'd0, stall_o},    32'd0);
    chk("swr_we",    {31'd0, we_o},       32'd0);
    chk("swr_wa",    {27'd0, wa_o},       32'd0);
    chk("swr_wdata", wdata_o,             32'd0);
    tick();
    chk("swr_ram600", {24'd0, ram[12'h600]}, 32'hBE);
    chk("swr_ram601", {24'd0, ram[12'h601]}, 32'hBA);
    chk("swr_ram602", {24'd0, ram[12'h602]}, 32'h5A);
    $display("txn sw_rst : ram600=%02h ram601=%02h ram602=%02h", ram[12'h600], ram[12'h601], ram[12'h602]);
    mem_e_i = 5'd0;
    res_i   = 32'd0;
    mem_n_i = 32'd0;
    wa_i    = 5'd0;
    rst     = 1'b0;
    tick();

    mem_op(E_LB, 32'h600, 32'd0, 5'd6, 1'b1, 16'hFFFF, cyc, stl);
    $display("txn lb_post: cycles=%0d wdata=%08h", cyc, wdata_o);
    chk("post_cycles", cyc, 4);
    chk("post_wdata",  wdata_o, 32'hFFFFFFBE);
    chk("post_wa",     {27'd0, wa_o}, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
